// File: rtl/usb_tx_pkg.sv
// Shared PHY-layer types for the USB transmitter: line states, FSM states and
// the NRZI helper used when putting the next bit on the line.
package types;

    typedef enum logic [1:0] {
        SE0 = 2'b00,
        J   = 2'b01,
        K   = 2'b10
    } d_port_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_EOP0 = 3'd3,
        ST_EOP1 = 3'd4,
        ST_EOP2 = 3'd5
    } tx_state_t;

    // Sent LSB first: seven zeros then a one.
    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;
    localparam logic [2:0] STUFF_LIMIT  = 3'd6;
    localparam logic [2:0] LAST_BIT     = 3'd7;

    // NRZI: a 0 toggles J<->K, a 1 holds the current line state.
    function automatic d_port_t nrzi_next(input d_port_t cur, input logic bit_v);
        d_port_t nxt;
        if (bit_v) begin
            nxt = cur;
        end else begin
            nxt = (cur == J) ? K : J;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/usb_tx.sv
// USB low/full-speed transmitter: SYNC, LSB-first bit-stuffed NRZI data, EOP.
// All line state advances only on clk_en (bit-rate) cycles.
module usb_tx
    import types::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic [7:0]    data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output types::d_port_t d_o,
    output logic          oe,
    output logic          busy
);

    tx_state_t r_state;
    logic [2:0] r_bit_cnt;
    logic [2:0] r_ones;
    logic [7:0] r_shift;
    d_port_t    r_line;
    logic       r_oe;
    logic       r_busy;

    tx_state_t w_state;
    logic [2:0] w_bit_cnt;
    logic [2:0] w_ones;
    logic [7:0] w_shift;
    d_port_t    w_line;
    logic       w_oe;
    logic       w_busy;
    logic       w_ready;
    logic       w_send;
    logic       w_bit;
    logic       w_stuff_due;

    // Next-state, next-line and handshake logic.
    always_comb begin
        w_state     = r_state;
        w_bit_cnt   = r_bit_cnt;
        w_ones      = r_ones;
        w_shift     = r_shift;
        w_line      = r_line;
        w_oe        = r_oe;
        w_busy      = r_busy;
        w_ready     = 1'b0;
        w_send      = 1'b0;
        w_bit       = 1'b0;
        w_stuff_due = (r_ones == STUFF_LIMIT);

        if (clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        w_state   = ST_SYNC;
                        w_bit_cnt = 3'd0;
                        w_ones    = 3'd0;
                        w_send    = 1'b1;
                        w_bit     = SYNC_PATTERN[0];
                        w_oe      = 1'b1;
                        w_busy    = 1'b1;
                    end else begin
                        w_line = J;
                        w_oe   = 1'b0;
                        w_busy = 1'b0;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    // A pending stuff bit goes out first; the byte position is held.
                    if (r_state == ST_DATA && w_stuff_due) begin
                        w_send = 1'b1;
                        w_bit  = 1'b0;
                    end else if (r_bit_cnt == LAST_BIT) begin
                        if (tx_valid) begin
                            w_ready   = 1'b1;
                            w_state   = ST_DATA;
                            w_bit_cnt = 3'd0;
                            w_send    = 1'b1;
                            w_bit     = data[0];
                            w_shift   = {1'b0, data[7:1]};
                        end else begin
                            w_state = ST_EOP0;
                            w_line  = SE0;
                        end
                    end else if (r_state == ST_SYNC) begin
                        w_send    = 1'b1;
                        w_bit     = SYNC_PATTERN[r_bit_cnt + 3'd1];
                        w_bit_cnt = r_bit_cnt + 3'd1;
                    end else begin
                        w_send    = 1'b1;
                        w_bit     = r_shift[0];
                        w_shift   = {1'b0, r_shift[7:1]};
                        w_bit_cnt = r_bit_cnt + 3'd1;
                    end
                end
                ST_EOP0: begin
                    w_state = ST_EOP1;
                    w_line  = SE0;
                end
                ST_EOP1: begin
                    w_state = ST_EOP2;
                    w_line  = J;
                end
                ST_EOP2: begin
                    w_state = ST_IDLE;
                    w_line  = J;
                    w_oe    = 1'b0;
                    w_busy  = 1'b0;
                end
                default: begin
                    w_state = ST_IDLE;
                    w_line  = J;
                    w_oe    = 1'b0;
                    w_busy  = 1'b0;
                end
            endcase

            if (w_send) begin
                w_line = nrzi_next(r_line, w_bit);
                w_ones = w_bit ? (r_ones + 3'd1) : 3'd0;
            end else begin
                w_ones = w_ones;
            end
        end else begin
            w_ready = 1'b0;
        end
    end

    // State and line registers; reset returns the line to idle J without EOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_ones    <= 3'd0;
            r_shift   <= 8'd0;
            r_line    <= J;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_bit_cnt <= w_bit_cnt;
            r_ones    <= w_ones;
            r_shift   <= w_shift;
            r_line    <= w_line;
            r_oe      <= w_oe;
            r_busy    <= w_busy;
        end
    end

    assign tx_ready = w_ready;
    assign d_o      = r_line;
    assign oe       = r_oe;
    assign busy     = r_busy;

endmodule

// File: doc/usb_tx.md
# usb_tx

USB low/full-speed transmitter, the transmit counterpart of the receiver in the same PHY layer. Takes bytes from the SIE over a valid/ready handshake and emits a complete packet line sequence: SYNC, LSB-first data with bit stuffing, NRZI encoding, then EOP. Bit timing comes from the same `clk_en` bit-rate enable as the receiver. The block does not depend on speed: low-speed J/K polarity is handled in the `d_port_t` mapping outside this block.

## Interface
- No parameters.
- `clk` in 1: system clock, 24 MHz.
- `reset` in 1: synchronous, active-high.
- `clk_en` in 1: one-cycle pulse per bit time; all line state advances only on cycles with `clk_en=1`.
- `data` in 8: byte from the SIE.
- `tx_valid` in 1: SIE has a byte. Held high for the whole packet; dropped after the last byte is accepted.
- `tx_ready` out 1: byte accepted. One-clk pulse; `data` is captured at this clk edge.
- `d_o` out `types::d_port_t`: line state driven (J, K or SE0).
- `oe` out 1: output enable for the transceiver.
- `busy` out 1: high from the first SYNC bit through the final EOP J bit.

## Operation
- States: IDLE, SYNC (bit counter 0..7), DATA (bit counter 0..7, stuff flag), EOP0, EOP1, EOP2.
- IDLE: `d_o=J`, `oe=0`, `busy=0`. On a `clk_en` cycle with `tx_valid=1`, go to SYNC and drive the first SYNC bit.
- SYNC sends logical 00000001 (NRZI on the line: K J K J K J K K).
- NRZI encoding: a 0 toggles the line J↔K; a 1 holds the line. The line is J before SYNC.
- Byte load point: the `clk_en` cycle where the last SYNC bit or data bit 7 is on the line, and no stuff bit is pending.
  - If `tx_valid=1` at the load point: `tx_ready=1` for that cycle, load `data` into the shift register, next bit is bit 0, LSB first.
  - If `tx_valid=0` at the load point: go to EOP0.
- Bit stuffing:
  - The ones counter clears at SYNC start and counts the final SYNC 1.
  - After 6 consecutive 1s, the next bit time sends a 0. The shift register and bit counter are held during that bit, and the counter clears.
  - Stuffing runs across byte boundaries.
  - A stuff bit due after the last data bit is sent before EOP.
  - Any 0 clears the counter.
- EOP sequence: EOP0 drives SE0, EOP1 drives SE0, EOP2 drives J with `oe=1`. Then IDLE: `oe=0`, `busy=0`.
- `tx_valid` is ignored outside IDLE and the load points. `data` is only sampled on `tx_ready` cycles.
- Reset values: `d_o=J`, `oe=0`, `tx_ready=0`, `busy=0`, state IDLE, counters 0.
- Reset mid-packet: the next cycle shows J with `oe=0`. No EOP is sent.

## Timing
- `d_o`, `oe` and `busy` are registered and change only at clk edges where `clk_en=1`.
- `tx_ready` is combinational: `clk_en` AND load condition. It is never high when `clk_en=0`.
- Start latency: the edge that samples `tx_valid=1` in IDLE drives the first SYNC K. The first `tx_ready` comes 7 `clk_en` cycles later, during the 8th SYNC bit.
- Consecutive `tx_ready` pulses are 8 bit times apart, plus 1 per stuff bit inserted in the intervening byte.
- Packet length in bit times: 8 (SYNC) + 8·N (data) + stuff bits + 3 (EOP).

## Structure
- Package `types`: reuse `d_port_t` (J, K, SE0) shared with the receiver. Add constant `SYNC_PATTERN = 8'b1000_0000`, sent LSB first.
- Single module, no sub-module. The stuff/NRZI path is a few registers; keeping it inline keeps the hold and stuff interaction in one FSM.

## Test plan
- Byte 0xC3, `clk_en` every cycle.
  - Line: K J K J K J K K | K K J K J K K K | SE0 SE0 J, then J with `oe=0`.
  - Exactly one `tx_ready` pulse, on the 8th SYNC bit.
- Byte 0xFF.
  - Data line: K K K K K J J J J (stuff after the 5th data 1, counting the SYNC 1).
  - Then SE0 SE0 J.
- Byte 0xFC.
  - Data line: J K K K K K K K, then stuff J, then SE0 SE0 J.
  - The stuff bit precedes EOP.
- Bytes 0x00, 0x00 with `clk_en` every 2nd clk (full speed at 24 MHz).
  - Each `tx_ready` is 1 clk wide.
  - Two pulses 16 clks apart.
  - 16 alternating data bits starting with J.
  - EOP follows the last bit immediately.
- `reset` asserted during data bit 3 of byte 1.
  - Next clk: `d_o=J`, `oe=0`, `busy=0`, no further `tx_ready`.
  - A new packet afterwards starts with a correct SYNC.
